// File: rtl/pll_lock_detector.sv
// PLL lock qualifier: measures each reference period in pll_clk cycles,
// counts PFD up/down activity per period, and applies good/bad window
// hysteresis to produce a stable lock indication.
module pll_lock_detector #(
  parameter int unsigned DIV_N      = 10,
  parameter int unsigned FREQ_TOL   = 1,
  parameter int unsigned ERR_TOL    = 1,
  parameter int unsigned LOCK_CNT   = 8,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_ref,
  input  logic       up,
  input  logic       down,
  output logic       locked,
  output logic [1:0] lock_state,
  output logic [7:0] phase_err,
  output logic [7:0] period_meas,
  output logic       eval_pulse
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_LOSING   = 2'd3
  } state_e;

  localparam logic [7:0] DIV_N_C      = 8'(DIV_N);
  localparam logic [7:0] FREQ_TOL_C   = 8'(FREQ_TOL);
  localparam logic [7:0] ERR_TOL_C    = 8'(ERR_TOL);
  localparam logic [7:0] LOCK_CNT_C   = 8'(LOCK_CNT);
  localparam logic [7:0] UNLOCK_CNT_C = 8'(UNLOCK_CNT);
  localparam logic [7:0] TIMEOUT_C    = 8'(TIMEOUT);

  // reference synchroniser and edge detect
  logic ref_s1_q, ref_s1_d;
  logic ref_s2_q, ref_s2_d;
  logic ref_s3_q, ref_s3_d;
  logic ref_tick;

  // window accumulators and evaluation registers
  logic [7:0] period_acc_q, period_acc_d;
  logic [7:0] err_acc_q, err_acc_d;
  logic       first_win_q, first_win_d;
  logic [7:0] phase_err_q, phase_err_d;
  logic [7:0] period_meas_q, period_meas_d;
  logic       timeout_win_q, timeout_win_d;
  logic       eval_pulse_q, eval_pulse_d;

  // lock FSM
  state_e     state_q, state_d;
  logic [7:0] good_cnt_q, good_cnt_d;
  logic [7:0] bad_cnt_q, bad_cnt_d;
  logic       locked_q, locked_d;

  logic       err_in;
  logic       timeout_hit;
  logic       eval_fire;
  logic       discard;
  logic [7:0] period_diff;
  logic       win_good;
  logic [7:0] good_cnt_inc;
  logic [7:0] bad_cnt_inc;

  // synchroniser next-state and rising-edge detect
  always_comb begin
    ref_s1_d = clk_ref;
    ref_s2_d = ref_s1_q;
    ref_s3_d = ref_s2_q;
    ref_tick = ref_s2_q & ~ref_s3_q;
  end

  // synchroniser flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_s1_q <= 1'b0;
      ref_s2_q <= 1'b0;
      ref_s3_q <= 1'b0;
    end else begin
      ref_s1_q <= ref_s1_d;
      ref_s2_q <= ref_s2_d;
      ref_s3_q <= ref_s3_d;
    end
  end

  // window accumulation, evaluation latch and first-window discard
  always_comb begin
    err_in        = up | down;
    timeout_hit   = (period_acc_q == TIMEOUT_C);
    eval_fire     = ref_tick | timeout_hit;
    discard       = ref_tick & first_win_q;
    period_acc_d  = period_acc_q;
    err_acc_d     = err_acc_q;
    first_win_d   = first_win_q & ~ref_tick;
    phase_err_d   = phase_err_q;
    period_meas_d = period_meas_q;
    timeout_win_d = timeout_win_q;
    eval_pulse_d  = 1'b0;
    if (eval_fire) begin
      // the evaluating cycle starts the next window
      period_acc_d = 8'd1;
      err_acc_d    = {7'd0, err_in};
      if (!discard) begin
        phase_err_d   = err_acc_q;
        period_meas_d = period_acc_q;
        // a coincident reference edge wins over the timeout
        timeout_win_d = ~ref_tick;
        eval_pulse_d  = 1'b1;
      end
    end else begin
      if (period_acc_q != '1) begin
        period_acc_d = period_acc_q + 8'd1;
      end
      if (err_in && (err_acc_q != '1)) begin
        err_acc_d = err_acc_q + 8'd1;
      end
    end
  end

  // accumulator and evaluation flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_acc_q  <= '0;
      err_acc_q     <= '0;
      first_win_q   <= 1'b1;
      phase_err_q   <= '0;
      period_meas_q <= '0;
      timeout_win_q <= 1'b0;
      eval_pulse_q  <= 1'b0;
    end else begin
      period_acc_q  <= period_acc_d;
      err_acc_q     <= err_acc_d;
      first_win_q   <= first_win_d;
      phase_err_q   <= phase_err_d;
      period_meas_q <= period_meas_d;
      timeout_win_q <= timeout_win_d;
      eval_pulse_q  <= eval_pulse_d;
    end
  end

  // window classification from the latched measurements
  always_comb begin
    if (period_meas_q >= DIV_N_C) begin
      period_diff = period_meas_q - DIV_N_C;
    end else begin
      period_diff = DIV_N_C - period_meas_q;
    end
    win_good = ~timeout_win_q && (phase_err_q <= ERR_TOL_C) && (period_diff <= FREQ_TOL_C);
  end

  // FSM state and hysteresis counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_UNLOCKED;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      locked_q   <= locked_d;
    end
  end

  // FSM next state, stepped only on an evaluated window
  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    good_cnt_inc = good_cnt_q + 8'd1;
    bad_cnt_inc  = bad_cnt_q + 8'd1;
    if (eval_pulse_q) begin
      unique case (state_q)
        ST_UNLOCKED: begin
          if (win_good) begin
            if (LOCK_CNT_C == 8'd1) begin
              state_d    = ST_LOCKED;
              good_cnt_d = '0;
            end else begin
              state_d    = ST_ACQUIRE;
              good_cnt_d = 8'd1;
            end
          end
        end
        ST_ACQUIRE: begin
          if (!win_good) begin
            state_d    = ST_UNLOCKED;
            good_cnt_d = '0;
          end else if (good_cnt_inc >= LOCK_CNT_C) begin
            state_d    = ST_LOCKED;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_inc;
          end
        end
        ST_LOCKED: begin
          if (!win_good) begin
            if (UNLOCK_CNT_C == 8'd1) begin
              state_d   = ST_UNLOCKED;
              bad_cnt_d = '0;
            end else begin
              state_d   = ST_LOSING;
              bad_cnt_d = 8'd1;
            end
          end
        end
        ST_LOSING: begin
          if (win_good) begin
            state_d   = ST_LOCKED;
            bad_cnt_d = '0;
          end else if (bad_cnt_inc >= UNLOCK_CNT_C) begin
            state_d   = ST_UNLOCKED;
            bad_cnt_d = '0;
          end else begin
            bad_cnt_d = bad_cnt_inc;
          end
        end
      endcase
    end
  end

  // registered lock flag tracks the state being entered
  always_comb begin
    locked_d = (state_d == ST_LOCKED) || (state_d == ST_LOSING);
  end

  assign locked      = locked_q;
  assign lock_state  = state_q;
  assign phase_err   = phase_err_q;
  assign period_meas = period_meas_q;
  assign eval_pulse  = eval_pulse_q;

endmodule

// File: tb/tb_pll_lock_detector.sv
// Bench for pll_lock_detector: table of reference windows driven in order,
// expected per-window results queued at each reference rise and compared
// when eval_pulse appears; hand-written timeout and reset sequences.
module tb_pll_lock_detector;

  typedef struct {
    int unsigned period;
    int unsigned up_len;
    int unsigned dn_len;
    bit          chk_meas;
    logic [7:0]  exp_phase;
    logic [7:0]  exp_period;
    logic [1:0]  exp_state;
    logic        exp_locked;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       clk_ref;
  logic       up;
  logic       down;
  logic       locked;
  logic [1:0] lock_state;
  logic [7:0] phase_err;
  logic [7:0] period_meas;
  logic       eval_pulse;

  int   checks = 0;
  int   errors = 0;
  int   eval_count = 0;
  int   win_no = 0;
  vec_t sb_q[$];
  vec_t pend;
  bit   pend_valid = 0;
  vec_t prev;
  bit   have_prev = 0;
  vec_t tbl[39];

  pll_lock_detector #(
    .DIV_N(10),
    .FREQ_TOL(1),
    .ERR_TOL(1),
    .LOCK_CNT(8),
    .UNLOCK_CNT(4),
    .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clk_ref(clk_ref),
    .up(up),
    .down(down),
    .locked(locked),
    .lock_state(lock_state),
    .phase_err(phase_err),
    .period_meas(period_meas),
    .eval_pulse(eval_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic vec_t mk(input int unsigned per, input int unsigned upl,
                              input int unsigned dnl, input logic [7:0] ph,
                              input logic [1:0] st, input logic lk);
    vec_t v;
    v.period     = per;
    v.up_len     = upl;
    v.dn_len     = dnl;
    v.chk_meas   = 1'b1;
    v.exp_phase  = ph;
    v.exp_period = 8'(per);
    v.exp_state  = st;
    v.exp_locked = lk;
    return v;
  endfunction

  // One reference period starting with a clk_ref rise; the window that this
  // rise closes has its expectation queued now.
  task automatic start_window(input vec_t v);
    if (have_prev) sb_q.push_back(prev);
    prev      = v;
    have_prev = 1'b1;
    for (int c = 0; c < int'(v.period); c++) begin
      @(negedge clk);
      clk_ref = (c < int'(v.period / 2));
      up      = (c >= 4) && (c < 4 + int'(v.up_len));
      down    = (c >= 4) && (c < 4 + int'(v.dn_len));
    end
  endtask

  // Scoreboard: measurements on eval_pulse, state/locked one cycle later
  always @(negedge clk) begin
    if (pend_valid) begin
      chk($sformatf("lock_state win%0d", win_no), int'(lock_state), int'(pend.exp_state));
      chk($sformatf("locked win%0d", win_no), int'(locked), int'(pend.exp_locked));
      pend_valid = 1'b0;
    end
    if (eval_pulse === 1'b1) begin
      eval_count++;
      win_no++;
      if (sb_q.size() == 0) begin
        chk($sformatf("unexpected_eval win%0d", win_no), 1, 0);
      end else begin
        pend = sb_q.pop_front();
        if (pend.chk_meas) begin
          chk($sformatf("phase_err win%0d", win_no), int'(phase_err), int'(pend.exp_phase));
          chk($sformatf("period_meas win%0d", win_no), int'(period_meas), int'(pend.exp_period));
        end
        pend_valid = 1'b1;
      end
    end
  end

  initial begin
    vec_t clean;
    vec_t v;
    int   cnt_snap;

    clean = mk(10, 0, 0, 8'd0, 2'd0, 1'b0);
    // acquire: 7 in ACQUIRE, LOCKED on the 8th good window
    for (int i = 0; i < 7; i++) tbl[i] = mk(10, 0, 0, 8'd0, 2'd1, 1'b0);
    tbl[7]  = mk(10, 0, 0, 8'd0, 2'd2, 1'b1);
    tbl[8]  = mk(10, 0, 0, 8'd0, 2'd2, 1'b1);
    // three 3-cycle up pulses: LOSING but never unlocked
    for (int i = 9; i < 12; i++) tbl[i] = mk(10, 3, 0, 8'd3, 2'd3, 1'b1);
    tbl[12] = mk(10, 0, 0, 8'd0, 2'd2, 1'b1);
    tbl[13] = mk(10, 0, 0, 8'd0, 2'd2, 1'b1);
    // tolerance edges
    tbl[14] = mk(9,  0, 0, 8'd0, 2'd2, 1'b1);
    tbl[15] = mk(11, 0, 0, 8'd0, 2'd2, 1'b1);
    tbl[16] = mk(10, 1, 1, 8'd1, 2'd2, 1'b1);
    tbl[17] = mk(12, 0, 0, 8'd0, 2'd3, 1'b1);
    tbl[18] = mk(10, 0, 0, 8'd0, 2'd2, 1'b1);
    tbl[19] = mk(10, 2, 2, 8'd2, 2'd3, 1'b1);
    tbl[20] = mk(10, 0, 0, 8'd0, 2'd2, 1'b1);
    // four period-13 windows drop lock
    for (int i = 21; i < 24; i++) tbl[i] = mk(13, 0, 0, 8'd0, 2'd3, 1'b1);
    tbl[24] = mk(13, 0, 0, 8'd0, 2'd0, 1'b0);
    // 5 good, one period-8 window, then 8 fresh good windows
    for (int i = 25; i < 30; i++) tbl[i] = mk(10, 0, 0, 8'd0, 2'd1, 1'b0);
    tbl[30] = mk(8, 0, 0, 8'd0, 2'd0, 1'b0);
    for (int i = 31; i < 38; i++) tbl[i] = mk(10, 0, 0, 8'd0, 2'd1, 1'b0);
    tbl[38] = mk(10, 0, 0, 8'd0, 2'd2, 1'b1);

    rst_n   = 1'b1;
    clk_ref = 1'b0;
    up      = 1'b0;
    down    = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset locked", int'(locked), 0);
    chk("reset lock_state", int'(lock_state), 0);
    chk("reset phase_err", int'(phase_err), 0);
    chk("reset period_meas", int'(period_meas), 0);
    chk("reset eval_pulse", int'(eval_pulse), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // first rise closes the reset window, which must be discarded
    start_window(tbl[0]);
    #1 chk("first_window_discard evals", eval_count, 0);
    for (int i = 1; i < 39; i++) start_window(tbl[i]);

    // reference stops: the window just opened ends in four timeouts
    start_window(clean);
    have_prev = 1'b0;
    sb_q.push_back(mk(255, 0, 0, 8'd0, 2'd3, 1'b1));
    sb_q.push_back(mk(255, 0, 0, 8'd0, 2'd3, 1'b1));
    sb_q.push_back(mk(255, 0, 0, 8'd0, 2'd3, 1'b1));
    sb_q.push_back(mk(255, 0, 0, 8'd0, 2'd0, 1'b0));
    for (int c = 0; c < 1090; c++) begin
      @(negedge clk);
      clk_ref = 1'b0;
      up      = 1'b0;
      down    = 1'b0;
    end
    #1 chk("timeout evals pending", sb_q.size(), 0);

    // restart: partial window is bad, then 8 good windows re-lock
    prev          = mk(10, 0, 0, 8'd0, 2'd0, 1'b0);
    prev.chk_meas = 1'b0;
    have_prev     = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      v = mk(10, 0, 0, 8'd0, (k == 8) ? 2'd2 : 2'd1, (k == 8));
      start_window(v);
    end

    // asynchronous reset while LOCKED
    @(negedge clk);
    chk("pre_reset locked", int'(locked), 1);
    chk("pre_reset period_meas", int'(period_meas), 10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset locked", int'(locked), 0);
    chk("async_reset lock_state", int'(lock_state), 0);
    chk("async_reset phase_err", int'(phase_err), 0);
    chk("async_reset period_meas", int'(period_meas), 0);
    chk("async_reset eval_pulse", int'(eval_pulse), 0);
    have_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt_snap = eval_count;
    start_window(mk(10, 0, 0, 8'd0, 2'd1, 1'b0));
    #1 chk("post_reset_discard evals", eval_count - cnt_snap, 0);
    start_window(mk(10, 0, 0, 8'd0, 2'd1, 1'b0));
    start_window(clean);
    have_prev = 1'b0;
    repeat (20) @(negedge clk);
    #1 chk("scoreboard drained", sb_q.size() + int'(pend_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_detector.md
Name: pll_lock_detector

Overview:
- Qualifies PLL lock from the PFD `up`/`down` pulses and the reference clock, all observed in the `pll_clk` domain.
- Replaces the single-cycle "no up/no down" lock flag with a per-reference-period phase and frequency check plus hysteresis.
- Sits directly downstream of PFD, in parallel with LPF; drives the top-level `locked` output.

Parameters:
- DIV_N, 10, expected `clk` cycles per reference period (100 MHz / 10 MHz).
- FREQ_TOL, 1, allowed |measured period − DIV_N| in `clk` cycles.
- ERR_TOL, 1, maximum `clk` cycles per window with `up` or `down` asserted.
- LOCK_CNT, 8, consecutive good windows to declare lock (1..255).
- UNLOCK_CNT, 4, consecutive bad windows to drop lock (1..255).
- TIMEOUT, 255, `clk` cycles without a reference edge before a forced bad window (> DIV_N+FREQ_TOL, ≤ 255).

Ports:
- clk  input  1  PLL output-domain clock (`pll_clk`).
- rst_n  input  1  asynchronous active-low reset.
- clk_ref  input  1  reference clock, asynchronous to `clk`.
- up  input  1  PFD up pulse, `clk` domain.
- down  input  1  PFD down pulse, `clk` domain.
- locked  output  1  qualified lock indicator.
- lock_state  output  2  FSM state: 0 UNLOCKED, 1 ACQUIRE, 2 LOCKED, 3 LOSING.
- phase_err  output  8  `up|down` cycle count of the last evaluated window.
- period_meas  output  8  `clk` cycle count of the last evaluated window.
- eval_pulse  output  1  one-cycle strobe when a window is evaluated.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, FSM UNLOCKED, all counters 0, `first_win`=1.
- Reference synchroniser:
  - 2-flop synchroniser on `clk_ref`, then a rising-edge detect produces `ref_tick`.
  - `ref_tick` is high 3 `clk` edges after the `clk_ref` rise, ±1 for metastability.
- Window counters, both 8-bit and saturating at 255:
  - `period_acc` increments every cycle.
  - `err_acc` increments on cycles with `up|down`.
  - On `ref_tick`, `period_acc` reloads 1 and `err_acc` reloads (`up|down`), so the tick cycle belongs to the new window.
- Evaluation fires on `ref_tick`, or when `period_acc` reaches TIMEOUT (timeout evaluation).
  - On evaluation, `phase_err`/`period_meas` latch the accumulators and `eval_pulse`=1 on the next cycle.
  - The FSM updates on that same next cycle.
- First window: the window ending at the first `ref_tick` after reset is discarded.
  - `first_win` clears; no `eval_pulse`, no FSM step, no output latch.
  - A timeout evaluation is never discarded.
- Window classification:
  - good = (`phase_err` ≤ ERR_TOL) && (|`period_meas` − DIV_N| ≤ FREQ_TOL).
  - Timeout windows are always bad.
  - Use unsigned subtract-and-compare (no signed wrap).
- FSM, evaluated only on `eval_pulse`:
  - UNLOCKED: good → ACQUIRE with `good_cnt`=1; go directly to LOCKED if LOCK_CNT==1. Bad → stay.
  - ACQUIRE: good → `good_cnt`++; LOCKED when `good_cnt` reaches LOCK_CNT. Bad → UNLOCKED, `good_cnt`=0.
  - LOCKED: bad → LOSING with `bad_cnt`=1; go directly to UNLOCKED if UNLOCK_CNT==1. Good → stay.
  - LOSING: bad → `bad_cnt`++; UNLOCKED when `bad_cnt` reaches UNLOCK_CNT, with `bad_cnt`=0. Good → LOCKED, `bad_cnt`=0.
- `locked` is registered: 1 in LOCKED and LOSING, 0 otherwise. It updates the cycle after `eval_pulse`.
- Simultaneous `ref_tick` and timeout: treat as a single `ref_tick` evaluation.
- `up` and `down` both high counts one error cycle.
- Reset mid-window or mid-LOCKED: immediate return to reset values; the first post-reset window is discarded again.

Test Plan:
- Reset, then 20 ref periods of exactly 10 `clk` with no up/down → first window discarded; `eval_pulse` every 10 cycles; `lock_state` goes 1 on eval 1 and 2 after eval 8; `locked`=1 one cycle after eval 8.
- Locked, then 3 windows each with a 3-cycle `up` pulse, then clean windows → LOSING after bad 1; `locked` stays 1; returns to LOCKED on the next good window; never unlocks.
- Locked, then 4 consecutive windows with period 13 → `period_meas`=13, state 3 after bad 1, state 0 after bad 4, `locked`=0 one cycle later.
- In ACQUIRE after 5 good windows, inject one period-8 window → UNLOCKED; 8 fresh good windows needed for LOCKED.
- Locked, then stop `clk_ref` → timeout eval every 255 cycles; `period_meas`=255; `locked`=0 after the 4th timeout; restarting `clk_ref` re-acquires in 8 windows.
- Boundary: windows with period 9 and 11, and `phase_err`=1 → all classified good; period 12 or `phase_err`=2 → bad. Assert `rst_n` mid-LOCKED → all outputs 0 asynchronously.
